// File: rtl/task_2_pkg.sv
// Shared types and default sizing for the task_2 answer path.
package task_2_pkg;

   localparam int BYTE_W       = 8;
   localparam int DEF_DEPTH    = 2048;
   localparam int DEF_SIZE_W   = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      SEND = 2'd2
   } state_e;

endpackage

// File: rtl/packet_ram.sv
// Simple dual-port byte RAM: synchronous write, registered read (read-before-write on collision).
module packet_ram
   import task_2_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [BYTE_W-1:0] i_wdata,
   input  logic [AW-1:0]     i_raddr,
   output logic [BYTE_W-1:0] o_rdata
);

   logic [BYTE_W-1:0] mem_q [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem_q[i_waddr] <= i_wdata;
      end
      o_rdata <= mem_q[i_raddr];
   end

endmodule

// File: rtl/answer_packetizer.sv
// Buffers one answer packet from the serializer and replays it over the ready/valid answer port.
// Optional trailing XOR checksum byte: define ANSWER_PKT_CHECKSUM_EN.
module answer_packetizer
   import task_2_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int SIZE_W = DEF_SIZE_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [BYTE_W-1:0] i_data,
   input  logic              i_data_valid,
   input  logic              i_data_last,
   input  logic              i_tmanager_ready,
   output logic              o_tanswer_ready,
   output logic [BYTE_W-1:0] o_tanswer_data,
   output logic              o_tanswer_data_last,
   output logic [SIZE_W-1:0] o_packet_size_in_bytes,
   output logic              o_busy,
   output logic              o_full,
   output logic              o_overflow
);

   localparam int AW = $clog2(DEPTH);
   // Counts must reach DEPTH plus an optional checksum byte.
   localparam int CW = AW + 2;

   state_e            state_q;
   logic [AW-1:0]     wr_ptr_q;
   logic [CW-1:0]     cnt_q;
   logic [CW-1:0]     rd_q;
   logic [CW-1:0]     len_q;
   logic [SIZE_W-1:0] size_q;
   logic              busy_q;
   logic              last_q;
   logic              ovf_q;
   logic              fwd_q;
   logic [BYTE_W-1:0] fwd_data_q;

   logic              store;
   logic              close;
   logic              xfer;
   logic              end_pkt;
   logic [CW-1:0]     cnt_d;
   logic [CW-1:0]     len_d;
   logic [CW-1:0]     rd_next;
   logic [AW-1:0]     rd_addr;
   logic [BYTE_W-1:0] ram_rdata;
   logic [BYTE_W-1:0] payload_byte;
   logic [BYTE_W-1:0] byte_out;

   assign store   = i_data_valid && (state_q != SEND) && (cnt_q < CW'(DEPTH));
   assign close   = i_data_valid && i_data_last && (state_q != SEND);
   assign xfer    = busy_q && i_tmanager_ready;
   assign end_pkt = xfer && last_q;
   assign cnt_d   = cnt_q + CW'(store);
   assign rd_next = rd_q + CW'(1);
   // Look one byte ahead on a transfer so the RAM's registered read keeps full throughput.
   assign rd_addr = xfer ? rd_next[AW-1:0] : rd_q[AW-1:0];

`ifdef ANSWER_PKT_CHECKSUM_EN
   localparam logic [CW-1:0] EXTRA = CW'(1);

   logic [BYTE_W-1:0] chk_q;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         chk_q <= '0;
      end else if (end_pkt) begin
         chk_q <= '0;
      end else if (store) begin
         chk_q <= chk_q ^ i_data;
      end
   end

   // The checksum occupies the slot right after the last stored payload byte.
   assign byte_out = (rd_q == cnt_q) ? chk_q : payload_byte;
`else
   localparam logic [CW-1:0] EXTRA = '0;

   assign byte_out = payload_byte;
`endif

   assign len_d = cnt_d + EXTRA;

   packet_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .i_clk   (i_clk),
      .i_we    (store),
      .i_waddr (wr_ptr_q),
      .i_wdata (i_data),
      .i_raddr (rd_addr),
      .o_rdata (ram_rdata)
   );

   // A byte written at the same edge it is read (single-byte packet) comes from the bypass.
   assign payload_byte = fwd_q ? fwd_data_q : ram_rdata;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         cnt_q      <= '0;
         rd_q       <= '0;
         len_q      <= '0;
         size_q     <= '0;
         busy_q     <= 1'b0;
         last_q     <= 1'b0;
         ovf_q      <= 1'b0;
         fwd_q      <= 1'b0;
         fwd_data_q <= '0;
      end else begin
         fwd_q      <= store && (wr_ptr_q == rd_addr);
         fwd_data_q <= i_data;
         case (state_q)
            IDLE, FILL: begin
               if (store) begin
                  wr_ptr_q <= wr_ptr_q + 1'b1;
                  cnt_q    <= cnt_d;
               end
               if (i_data_valid && !store) begin
                  ovf_q <= 1'b1;
               end
               if (close) begin
                  state_q <= SEND;
                  busy_q  <= 1'b1;
                  rd_q    <= '0;
                  len_q   <= len_d;
                  size_q  <= SIZE_W'(len_d);
                  last_q  <= (len_d == CW'(1));
               end else if (i_data_valid) begin
                  state_q <= FILL;
               end
            end
            SEND: begin
               if (i_data_valid) begin
                  ovf_q <= 1'b1;
               end
               if (end_pkt) begin
                  state_q  <= IDLE;
                  busy_q   <= 1'b0;
                  last_q   <= 1'b0;
                  rd_q     <= '0;
                  len_q    <= '0;
                  wr_ptr_q <= '0;
                  cnt_q    <= '0;
               end else if (xfer) begin
                  rd_q   <= rd_next;
                  last_q <= (rd_next == len_q - CW'(1));
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign o_tanswer_ready        = busy_q;
   assign o_busy                 = busy_q;
   assign o_tanswer_data         = busy_q ? byte_out : '0;
   assign o_tanswer_data_last    = last_q;
   assign o_packet_size_in_bytes = size_q;
   assign o_full                 = (cnt_q == CW'(DEPTH));
   assign o_overflow             = ovf_q;

endmodule
